// File: rtl/xnor_parity_accum.sv
// rtl/xnor_parity_accum.sv - multi-beat XOR/XNOR frame parity reducer with error counter
module xnor_parity_accum #(
    parameter int WIDTH = 8,
    parameter int CNT_W = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [WIDTH-1:0] din,
    input  logic             din_valid,
    input  logic             din_last,
    input  logic             mode,
    input  logic             exp_par,
    output logic             dout,
    output logic             dout_valid,
    output logic             par_err,
    output logic [CNT_W-1:0] err_cnt,
    output logic             busy
);

    typedef enum logic {IDLE = 1'b0, ACCUM = 1'b1} state_t;

    state_t             state_q, state_d;
    logic               acc_q, acc_d;
    logic               mode_r_q, mode_r_d;
    logic               dout_q, dout_d;
    logic               dout_valid_q, dout_valid_d;
    logic               par_err_q, par_err_d;
    logic [CNT_W-1:0]   err_cnt_q, err_cnt_d;

    logic beat_par;
    logic frame_par;
    logic mode_used;
    logic result;
    logic mismatch;

    assign beat_par = ^din;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q      <= IDLE;
            acc_q        <= 1'b0;
            mode_r_q     <= 1'b0;
            dout_q       <= 1'b0;
            dout_valid_q <= 1'b0;
            par_err_q    <= 1'b0;
            err_cnt_q    <= '0;
        end else begin
            state_q      <= state_d;
            acc_q        <= acc_d;
            mode_r_q     <= mode_r_d;
            dout_q       <= dout_d;
            dout_valid_q <= dout_valid_d;
            par_err_q    <= par_err_d;
            err_cnt_q    <= err_cnt_d;
        end
    end

    always_comb begin
        state_d = state_q;
        if (din_valid) begin
            state_d = din_last ? IDLE : ACCUM;
        end
    end

    // A first beat uses the live mode; later beats use the mode latched on the first beat.
    always_comb begin
        frame_par = (state_q == ACCUM) ? (acc_q ^ beat_par) : beat_par;
        mode_used = (state_q == ACCUM) ? mode_r_q : mode;
        result    = frame_par ^ mode_used;
        mismatch  = result ^ exp_par;

        acc_d        = acc_q;
        mode_r_d     = mode_r_q;
        dout_d       = dout_q;
        dout_valid_d = 1'b0;
        par_err_d    = par_err_q;
        err_cnt_d    = err_cnt_q;

        if (din_valid) begin
            if (din_last) begin
                dout_d       = result;
                dout_valid_d = 1'b1;
                par_err_d    = mismatch;
                if (mismatch && (err_cnt_q != {CNT_W{1'b1}})) begin
                    err_cnt_d = err_cnt_q + CNT_W'(1);
                end
            end else begin
                acc_d = frame_par;
                if (state_q == IDLE) begin
                    mode_r_d = mode;
                end
            end
        end
    end

    always_comb begin
        busy       = (state_q == ACCUM);
        dout       = dout_q;
        dout_valid = dout_valid_q;
        par_err    = par_err_q;
        err_cnt    = err_cnt_q;
    end

endmodule

// File: doc/xnor_parity_accum.md
XNOR_PARITY_ACCUM -- requirements
Module: xnor_parity_accum

Interface
REQ-001 Parameter WIDTH, default 8: bit width of each input beat; legal range 1..64.
REQ-002 Parameter CNT_W, default 8: width of the frame error counter; legal range 1..32.
REQ-003 Port clk, input, 1: single clock; all state updates on the rising edge.
REQ-004 Port rst_n, input, 1: reset, synchronous and active-low.
REQ-005 Port din, input, WIDTH: data beat.
REQ-006 Port din_valid, input, 1: din, din_last and exp_par are valid this cycle.
REQ-007 Port din_last, input, 1: the current valid beat is the final beat of its frame.
REQ-008 Port mode, input, 1: 0 = XOR (even) reduction; 1 = XNOR (odd) reduction.
REQ-009 Port exp_par, input, 1: expected frame result; sampled only on the last beat.
REQ-010 Port dout, output, 1: frame reduction result.
REQ-011 Port dout_valid, output, 1: one-cycle pulse qualifying dout and par_err.
REQ-012 Port par_err, output, 1: dout differs from the sampled exp_par.
REQ-013 Port err_cnt, output, CNT_W: saturating count of frames with par_err = 1.
REQ-014 Port busy, output, 1: a frame is open (first beat accepted, last not yet seen).

Function
REQ-015 Beat parity p SHALL be the XOR of all WIDTH bits of din.
REQ-016 The FSM SHALL have two states, IDLE and ACCUM; busy SHALL be 1 only in ACCUM.
REQ-017 IDLE, din_valid=1, din_last=0: acc <= p, mode_r <= mode, go to ACCUM.
REQ-018 IDLE, din_valid=1, din_last=1: single-beat frame; result is produced from p and the current mode; FSM stays in IDLE.
REQ-019 ACCUM, din_valid=1, din_last=0: acc <= acc ^ p; FSM stays in ACCUM.
REQ-020 ACCUM, din_valid=1, din_last=1: result is produced from acc ^ p and mode_r; FSM returns to IDLE.
REQ-021 din_valid=0: acc, mode_r and state SHALL hold; no beat is accepted.
REQ-022 mode SHALL be sampled only on the first beat of a frame; changes to mode mid-frame SHALL be ignored.
REQ-023 Frame result r SHALL be final_parity ^ mode_used; r is the XNOR of all frame bits when mode_used = 1.
REQ-024 In the cycle after the last-beat cycle:
- dout = r
- dout_valid = 1
- par_err = (r != exp_par_sampled)
REQ-025 dout_valid SHALL be 1 for exactly one cycle per frame.
REQ-026 dout and par_err SHALL hold their last values while dout_valid = 0.
REQ-027 err_cnt SHALL increment by 1 in the same cycle that dout_valid = 1 and par_err = 1.
REQ-028 err_cnt SHALL saturate at 2^CNT_W-1 and SHALL NOT wrap.
REQ-029 A new frame may start in the cycle immediately after a last beat (back-to-back frames) with no bubble; results SHALL pipeline correctly.
REQ-030 Frame length is unbounded; the accumulator SHALL have no beat-count limit.

Reset
REQ-031 While rst_n = 0 at a clock edge, the block SHALL set state = IDLE and all of the following to 0: acc, mode_r, dout, dout_valid, par_err, err_cnt, busy.
REQ-032 Reset asserted mid-frame SHALL discard the partial frame; no dout_valid pulse SHALL be generated for it.
REQ-033 The first beat accepted after reset release SHALL start a new frame.

Verification
REQ-034 WIDTH=3, mode=1, one single-beat frame per value of din 000..111, each with exp_par=1.
- Required dout sequence: 1,0,0,1,0,1,1,0, one cycle after each beat.
- par_err = 1 exactly where dout = 0.
- err_cnt = 4 at the end.
REQ-035 WIDTH=8, mode=0, beats 8'h01, 8'h03, 8'h07 (last), exp_par=0.
- busy = 1 after beat 1 and after beat 2.
- One cycle after beat 3: dout = 0, dout_valid pulses, par_err = 0.
REQ-036 Same three-beat frame with din_valid=0 gaps between beats and mode toggled mid-frame:
- Result identical to REQ-035.
- Exactly one dout_valid pulse.
REQ-037 Back-to-back frames, WIDTH=8, mode=1:
- Frame 1: single beat 8'hFF; required dout = 1.
- Frame 2: beats 8'h01, 8'h00 (last); required dout = 0.
- Two dout_valid pulses on consecutive frame boundaries.
REQ-038 CNT_W=2, six consecutive single-beat frames with mismatching exp_par:
- err_cnt sequence 1, 2, 3, 3, 3, 3.
REQ-039 Open a frame with two beats, then drive rst_n = 0 for one cycle:
- busy = 0, err_cnt = 0, and no dout_valid pulse.
- A following single-beat frame 8'h01 with mode=0 yields dout = 1.
